// File: rtl/sin_gen_dds.sv
// sin_gen_dds: direct-digital-synthesis sine source.
//
// A phase accumulator advanced by a runtime tuning word feeds a three-stage
// pipeline: phase offset add, quarter-wave LUT lookup with quadrant folding,
// then sign restore and amplitude scaling. Every register advances only on
// clk_en, so the block runs at the downstream modulator's sample rate.
//
// Output handshake: out_valid is a valid-only strobe with no ready and no
// backpressure. It is high for exactly one clk after each enabled edge that
// produced a real sample. out is stable from that cycle until the next
// enabled edge, and the consumer must take it while out_valid is high.
module sin_gen_dds #(
  parameter int PHASE_W    = 32,
  parameter int LUT_ADDR_W = 8,
  parameter int DATA_W     = 16,
  parameter int AMP_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic [PHASE_W-1:0]       ftw,
  input  logic [PHASE_W-1:0]       phase_off,
  input  logic [AMP_W-1:0]         amp,
  input  logic                     sync,
  output logic signed [DATA_W-1:0] out,
  output logic                     out_valid
);

  localparam int LUT_N  = 2 ** LUT_ADDR_W;
  localparam int PROD_W = DATA_W + AMP_W + 1;
  localparam real PI    = 3.14159265358979323846;

  // Quarter-wave magnitude at the centre of bucket k. The half-bucket offset
  // makes the folded address map exactly onto the mirrored quadrants, so no
  // special case is needed at 0, pi/2, pi or 3pi/2.
  function automatic logic [DATA_W-2:0] lut_val(input int k);
    real full_scale;
    real x;
    full_scale = (2.0 ** (DATA_W - 1)) - 1.0;
    x = full_scale * $sin(PI / 2.0 * ($itor(k) + 0.5) / $itor(LUT_N));
    return (DATA_W-1)'($rtoi(x + 0.5));
  endfunction

  // Constant table, filled at elaboration. Magnitudes only; the sign comes
  // from the quadrant.
  logic [DATA_W-2:0] lut [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    assign lut[k] = lut_val(k);
  end

  // Pipeline state
  logic [PHASE_W-1:0]    acc;
  logic [PHASE_W-1:0]    ph;
  logic [DATA_W-2:0]     lut_q;
  logic                  neg;
  logic [1:0]            fill;

  // Stage-2 decode of the registered phase
  logic [1:0]            quad;
  logic [LUT_ADDR_W-1:0] lut_a;
  logic [LUT_ADDR_W-1:0] lut_addr;
  logic [DATA_W-2:0]     lut_rd;

  // Stage-3 arithmetic
  logic signed [DATA_W-1:0] samp_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W-1:0] out_next;

  // Quadrant and fine-address split; odd quadrants read the table backwards.
  always_comb begin
    quad     = ph[PHASE_W-1 -: 2];
    lut_a    = ph[PHASE_W-3 -: LUT_ADDR_W];
    lut_addr = quad[0] ? ~lut_a : lut_a;
    lut_rd   = lut[lut_addr];
  end

  // Phase bits finer than the LUT resolution are dropped (truncating lookup).
  if (PHASE_W > LUT_ADDR_W + 2) begin : g_ph_low
    logic unused_ph_low;
    assign unused_ph_low = ^ph[PHASE_W-3-LUT_ADDR_W:0];
  end

  // Restore the sign, then scale by amp/2^AMP_W. The arithmetic shift floors,
  // and since amp < 2^AMP_W the result always fits DATA_W.
  always_comb begin
    samp_s   = neg ? -$signed({1'b0, lut_q}) : $signed({1'b0, lut_q});
    prod     = PROD_W'(samp_s) * PROD_W'($signed({1'b0, amp}));
    out_next = DATA_W'(prod >>> AMP_W);
  end

  // Phase accumulator: natural mod-2^PHASE_W wrap; sync restarts at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
    end else if (clk_en) begin
      acc <= sync ? '0 : acc + ftw;
    end
  end

  // Stage 1: offset add on the pre-update accumulator value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ph <= '0;
    end else if (clk_en) begin
      ph <= acc + phase_off;
    end
  end

  // Stage 2: table read and quadrant sign capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lut_q <= '0;
      neg   <= 1'b0;
    end else if (clk_en) begin
      lut_q <= lut_rd;
      neg   <= quad[1];
    end
  end

  // Stage 3: scaled signed sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out <= '0;
    end else if (clk_en) begin
      out <= out_next;
    end
  end

  // Fill counter: out_valid only once the pipeline holds a real sample, i.e.
  // from the third enabled edge after reset onwards. sync does not flush, so
  // the counter is left alone on sync.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fill      <= 2'd0;
      out_valid <= 1'b0;
    end else if (clk_en) begin
      fill      <= (fill == 2'd3) ? fill : fill + 2'd1;
      out_valid <= (fill >= 2'd2);
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sin_gen_dds.sv
// tb_sin_gen_dds: directed bench for sin_gen_dds with a scoreboard queue of
// hand-derived samples and a floating-point reference for the fine sweep.
module tb_sin_gen_dds;

  localparam int PHASE_W    = 32;
  localparam int LUT_ADDR_W = 8;
  localparam int DATA_W     = 16;
  localparam int AMP_W      = 16;
  localparam real PI        = 3.14159265358979323846;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     clk_en;
  logic [PHASE_W-1:0]       ftw;
  logic [PHASE_W-1:0]       phase_off;
  logic [AMP_W-1:0]         amp;
  logic                     sync;
  logic signed [DATA_W-1:0] out;
  logic                     out_valid;

  sin_gen_dds #(
    .PHASE_W    (PHASE_W),
    .LUT_ADDR_W (LUT_ADDR_W),
    .DATA_W     (DATA_W),
    .AMP_W      (AMP_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .ftw       (ftw),
    .phase_off (phase_off),
    .amp       (amp),
    .sync      (sync),
    .out       (out),
    .out_valid (out_valid)
  );

  // ---------------- scoreboard ----------------
  logic signed [DATA_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int edges    = 0;
  int last_exp = 0;
  int sb_tol   = 0;
  int quarter[4] = '{100, 32766, -101, -32767};

  task automatic check(input string tag, input int got, input int exp, input int tol);
    int d;
    n_checks++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rst       = 1'b0;
      clk_en    = 1'b1;
      sync      = 1'($urandom_range(0, 1));
      ftw       = $urandom;
      phase_off = $urandom;
      amp       = AMP_W'($urandom_range(0, 65535));
      tick();
      check("rst_out", out, 0, 0);
      check("rst_valid", int'(out_valid), 0, 0);
    end
    rst      = 1'b1;
    sync     = 1'b0;
    clk_en   = 1'b0;
    edges    = 0;
    last_exp = 0;
    exp_q.delete();
  endtask

  task automatic set_cfg(input logic [PHASE_W-1:0] f, input logic [PHASE_W-1:0] o,
                         input logic [AMP_W-1:0] a);
    ftw       = f;
    phase_off = o;
    amp       = a;
  endtask

  task automatic push(input int v);
    exp_q.push_back(DATA_W'(v));
  endtask

  task automatic push_quarter(input int start, input int n);
    for (int i = 0; i < n; i++) push(quarter[(start + i) % 4]);
  endtask

  // One clock with the given enable/sync; checks out_valid every cycle, the
  // held value on disabled cycles, and scoreboard samples on valid cycles.
  task automatic drive_edge(input logic en, input logic sy, input string tag);
    logic vexp;
    logic signed [DATA_W-1:0] e;
    clk_en = en;
    sync   = sy;
    tick();
    if (en) edges++;
    vexp = en && (edges >= 3);
    check({tag, "_valid"}, int'(out_valid), int'(vexp), 0);
    if (!en) begin
      check({tag, "_hold"}, out, last_exp, 0);
    end else if (vexp) begin
      if (exp_q.size() == 0) begin
        check({tag, "_sb_empty"}, 0, 1, 0);
      end else begin
        e = exp_q.pop_front();
        check(tag, out, e, sb_tol);
        last_exp = e;
      end
    end
    sync = 1'b0;
  endtask

  // Reference sample: ideal sine at the centre of the LUT bucket, rounded to
  // the table magnitude, then scaled by 65535/65536 and floored.
  function automatic int model(input logic [PHASE_W-1:0] p);
    real v;
    real l;
    v = 32767.0 * $sin(2.0 * PI * (real'(longint'(p)) + 2097152.0) / 4294967296.0);
    if (v >= 0.0) l = $floor(v + 0.5);
    else          l = -$floor(-v + 0.5);
    return $rtoi($floor(l * 65535.0 / 65536.0));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [PHASE_W-1:0] p;
    int j;
    int m;

    rst = 1'b0; clk_en = 1'b0; sync = 1'b0;
    ftw = '0; phase_off = '0; amp = '0;

    // Reset held with random inputs; then quarter steps from phase 0.
    do_reset(5);
    set_cfg(32'h4000_0000, 32'h0, 16'hFFFF);
    push_quarter(0, 6);
    repeat (8) drive_edge(1'b1, 1'b0, "quarter");
    check("quarter_drain", exp_q.size(), 0, 0);

    // clk_en gating: sequence continues in order across disabled cycles.
    push_quarter(2, 4);
    for (int r = 0; r < 2; r++) begin
      drive_edge(1'b1, 1'b0, "gate");
      drive_edge(1'b0, 1'b0, "gate");
      drive_edge(1'b0, 1'b0, "gate");
      drive_edge(1'b1, 1'b0, "gate");
    end
    check("gate_drain", exp_q.size(), 0, 0);

    // Phase offset of a quarter turn shifts the sequence by one step.
    do_reset(2);
    set_cfg(32'h4000_0000, 32'h4000_0000, 16'hFFFF);
    push_quarter(1, 4);
    repeat (6) drive_edge(1'b1, 1'b0, "phoff");
    check("phoff_drain", exp_q.size(), 0, 0);

    // ftw==0 at peak phase with half amplitude: constant 16383.
    do_reset(2);
    set_cfg(32'h0, 32'h4000_0000, 16'd32768);
    repeat (3) push(16383);
    repeat (5) drive_edge(1'b1, 1'b0, "amp_half");
    check("amp_half_drain", exp_q.size(), 0, 0);

    // amp==0 silences every quadrant.
    do_reset(2);
    set_cfg(32'h4000_0000, 32'h0, 16'h0);
    repeat (4) push(0);
    repeat (6) drive_edge(1'b1, 1'b0, "amp_zero");
    check("amp_zero_drain", exp_q.size(), 0, 0);

    // sync at acc=2^31: two in-flight samples, then restart from phase 0.
    do_reset(2);
    set_cfg(32'h4000_0000, 32'h0, 16'hFFFF);
    push_quarter(0, 4);
    repeat (6) drive_edge(1'b1, 1'b0, "sync_pre");
    push(100); push(32766); push(-101); push(100); push(32766); push(-101);
    drive_edge(1'b1, 1'b1, "sync");
    repeat (5) drive_edge(1'b1, 1'b0, "sync");
    push(-32767); push(100);
    repeat (2) drive_edge(1'b1, 1'b0, "sync_post");
    // sync while disabled must leave the accumulator alone.
    drive_edge(1'b0, 1'b1, "sync_off");
    push(32766); push(-101); push(-32767);
    repeat (3) drive_edge(1'b1, 1'b0, "sync_off");
    check("sync_drain", exp_q.size(), 0, 0);

    // Fine sweep: one full period plus a few samples past the wrap.
    do_reset(2);
    set_cfg(32'h0040_0000, 32'h0, 16'hFFFF);
    clk_en = 1'b1;
    for (int k = 0; k < 2 + 1032; k++) begin
      tick();
      edges++;
      check("sweep_valid", int'(out_valid), int'(edges >= 3), 0);
      if (edges >= 3) begin
        j = edges - 3;
        p = PHASE_W'(j) << 22;
        m = model(p);
        check("sweep", out, m, 1);
        if (j >= 1024) begin
          check("sweep_wrap", out, model(PHASE_W'(j - 1024) << 22), 0);
        end else if (j >= 512 && (j % 64) == 0) begin
          check("sweep_sym", out, -model(PHASE_W'(j - 512) << 22) - 1, 0);
        end
      end
    end

    // Reset mid-sweep, coinciding with sync: zeros on the next cycle.
    rst  = 1'b0;
    sync = 1'b1;
    tick();
    check("midrst_out", out, 0, 0);
    check("midrst_valid", int'(out_valid), 0, 0);
    rst      = 1'b1;
    sync     = 1'b0;
    edges    = 0;
    last_exp = 0;
    exp_q.delete();
    push(100);
    push(model(32'h0040_0000));
    repeat (4) drive_edge(1'b1, 1'b0, "after_rst");
    check("after_rst_drain", exp_q.size(), 0, 0);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sin_gen_dds.md
Name: sin_gen_dds

Overview:
- Parametrised direct-digital-synthesis sine source. Successor to the fixed 50-point zero-order-hold generator.
- Adds:
  - phase accumulator with a runtime frequency tuning word;
  - runtime phase offset;
  - quarter-wave LUT built at elaboration;
  - runtime amplitude scaling;
  - phase sync.
- Drives signed test tones into the delta-sigma modulator at clk_en (sample) rate.

Parameters:
- PHASE_W, 32, phase accumulator / ftw / phase_off width (bits). Must be ≥ LUT_ADDR_W+2.
- LUT_ADDR_W, 8, log2 of quarter-wave LUT entries (256 entries).
- DATA_W, 16, signed output width.
- AMP_W, 16, unsigned amplitude word width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- clk_en  in  1  sample-rate enable. Pipeline and accumulator advance only when high.
- ftw  in  PHASE_W  frequency tuning word, unsigned. Sampled on every enabled cycle. f_out = f_en*ftw/2^PHASE_W.
- phase_off  in  PHASE_W  phase offset added after the accumulator. Sampled on every enabled cycle.
- amp  in  AMP_W  amplitude, unsigned. Gain = amp/2^AMP_W.
- sync  in  1  phase restart. Only effective when clk_en is high.
- out  out  DATA_W  signed sample.
- out_valid  out  1  high for the clk cycle following each enabled edge that produced a valid sample.

Behaviour:

Reset (rst==0 at posedge):
- acc, all pipeline registers, out, and out_valid go to 0.
- Fill counter clears.
- Reset has priority over clk_en and sync, including mid-operation.

Enable and hold:
- When clk_en==0, every register holds and out_valid<=0.

Accumulator:
- On an enabled edge: acc <= sync ? 0 : acc+ftw. Arithmetic is mod 2^PHASE_W (natural wrap).

Pipeline (advances on enabled edges only):
- S1: ph <= acc + phase_off, mod 2^PHASE_W. Uses the pre-update acc.
- S2 address decode:
  - q = ph[PHASE_W-1:PHASE_W-2];
  - a = ph[PHASE_W-3 -: LUT_ADDR_W];
  - addr = q[0] ? ~a : a.
- S2 register stage: lut_q <= LUT[addr]; neg <= q[1].
- S3 sign: s = neg ? -lut_q : lut_q.
- S3 scale: out <= (s * $signed({1'b0,amp})) >>> AMP_W. This is an arithmetic shift, i.e. floor. The result fits DATA_W; no saturation is needed.

LUT:
- LUT[k] = round((2^(DATA_W-1)-1) * sin(pi/2 * (k+0.5)/2^LUT_ADDR_W)), for k = 0..2^LUT_ADDR_W-1.
- Computed in an initial block or function at elaboration and stored unsigned.
- The half-LSB offset makes mirroring exact; there is no special case at quadrant edges.

Latency and out_valid:
- The acc value present at enabled edge n reaches out at enabled edge n+2.
- Fill counter: out_valid goes high (for one clk) after each enabled edge once 3 enabled edges have occurred since reset. It is 0 before that.

sync:
- Does not flush the pipeline: 2 in-flight samples still emerge.
- The sample at phase 0+phase_off follows them, and out_valid stays high.
- If sync and reset coincide, reset wins.

Boundary cases:
- ftw==0 gives a constant output.
- ftw ≥ 2^(PHASE_W-1) aliases; no check is made.
- amp==0 gives out==0.
- A change of ftw or phase_off takes effect on the next enabled edge. It is phase-continuous for ftw changes.

Test Plan:
1. Reset check: hold rst=0 for 5 cycles with clk_en=1 and random inputs -> out==0 and out_valid==0 throughout. After release, the first out_valid occurs after the 3rd enabled edge.
2. Quarter-step sequence (defaults): ftw=2^30, phase_off=0, amp=65535, clk_en=1 -> out repeats 100, 32766, -101, -32767.
   - Derivation: LUT[0]=101, LUT[255]=32767, and (101*65535)>>>16=100.
3. clk_en gating: same setup as scenario 2 with clk_en toggling 1,0,0,1 -> out and acc hold during the 0 cycles. out_valid is high only after enabled edges, and the sequence order is unchanged.
4. phase_off: phase_off=2^30 on top of scenario 2 -> sequence shifts by one: 32766, -101, -32767, 100.
   - Separately, amp=32768 with phase 2^30 -> out = 32767*32768>>>16 = 16383.
5. sync: pulse sync mid-stream in scenario 2 while acc=2^31 -> two more in-flight samples appear, then 100, 32766, … restarts.
   - Also: sync with clk_en=0 -> no effect.
6. Fine-ftw sweep: ftw=2^22 for 1024 enabled cycles -> one full period.
   - Bench compares every sample to a floating-point model within ±1 LSB.
   - Checks odd symmetry and wrap at acc overflow.
   - Then assert rst mid-sweep -> zeros next cycle.
